// File: rtl/mux_n_buf.sv
// N-input word multiplexer feeding a 2-entry valid/ready output buffer.
// Optional sticky out-of-range select flag enabled by defining MUX_SEL_ERR_EN.
module mux_n_buf #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned N_INPUTS = 7,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic [N_INPUTS*WIDTH-1:0] data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      err
);

  if (N_INPUTS < 2 || N_INPUTS > 16 || (2 ** SEL_W) < N_INPUTS) begin : g_bad_params
    $error("mux_n_buf: illegal N_INPUTS/SEL_W combination");
  end

  logic [WIDTH-1:0] words [N_INPUTS];
  logic [WIDTH-1:0] word_sel;

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic [SEL_W-1:0] head_sel_q, head_sel_d;
  logic [WIDTH-1:0] tail_data_q, tail_data_d;
  logic [SEL_W-1:0] tail_sel_q, tail_sel_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             push;
  logic             pop;

  for (genvar k = 0; k < N_INPUTS; k++) begin : g_unpack
    assign words[k] = data_in[k*WIDTH +: WIDTH];
  end

  // Out-of-range codes match no index and fall back to input 0.
  always_comb begin
    word_sel = words[0];
    for (int unsigned i = 1; i < N_INPUTS; i++) begin
      if (sel == SEL_W'(i)) word_sel = words[i];
    end
  end

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_sel_d  = head_sel_q;
    tail_data_d = tail_data_q;
    tail_sel_d  = tail_sel_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_data_d = word_sel;
          head_sel_d  = sel;
        end else begin
          tail_data_d = word_sel;
          tail_sel_d  = sel;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // Head keeps its last value when the buffer drains to empty.
        if (count_q == 2'd2) begin
          head_data_d = tail_data_q;
          head_sel_d  = tail_sel_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Only reachable with count 1: the new entry replaces the head.
        head_data_d = word_sel;
        head_sel_d  = sel;
      end
      default: ;
    endcase
    in_ready_d  = (count_d != 2'd2);
    out_valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_sel_q  <= '0;
      tail_data_q <= '0;
      tail_sel_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_sel_q  <= head_sel_d;
      tail_data_q <= tail_data_d;
      tail_sel_q  <= tail_sel_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = head_data_q;
  assign sel_out   = head_sel_q;

`ifdef MUX_SEL_ERR_EN
  localparam logic [SEL_W:0] N_LIMIT = (SEL_W+1)'(N_INPUTS);

  logic err_q, err_d;
  logic sel_oob;

  assign sel_oob = ({1'b0, sel} >= N_LIMIT);

  always_comb begin
    err_d = err_q | (push && sel_oob);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
